reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of implemented registers (2..2^ADDR).
REQ-003 Parameter ADDR, default 3, address width in bits.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-high.
REQ-006 WrEn  input  1  write request this cycle.
REQ-007 WrAddr  input  ADDR  write address.
REQ-008 WrData  input  WIDTH  write data.
REQ-009 WrMask  input  WIDTH  per-bit write enable; 1 = bit updated.
REQ-010 RdEnA / RdEnB  input  1  read request, port A / port B.
REQ-011 RdAddrA / RdAddrB  input  ADDR  read address, port A / port B.
REQ-012 RdDataA / RdDataB  output  WIDTH  registered read data.
REQ-013 RdValidA / RdValidB  output  1  RdData of that port valid this cycle.
REQ-014 AddrErr  output  1  sticky flag: out-of-range access has occurred.

Function
REQ-015 Write: on an edge with WrEn=1 and WrAddr<DEPTH, reg[WrAddr] <= (reg & ~WrMask) | (WrData & WrMask).
REQ-016 WrMask all-zero with WrEn=1 leaves storage unchanged and is not an error.
REQ-017 Read latency is 1 cycle: RdEnX=1 at edge N drives RdDataX and RdValidX=1 after edge N.
REQ-018 RdValidX is 0 in any cycle following an edge with RdEnX=0; RdDataX then holds its last value.
REQ-019 Ports A and B are independent; both may read the same or different addresses in the same cycle.
REQ-020 Write-first bypass: same-edge WrEn=1 with WrAddr==RdAddrX (in range) returns the post-write masked-merge value on RdDataX.
REQ-021 Out-of-range write (WrAddr>=DEPTH, WrEn=1) is dropped with storage unchanged, and sets AddrErr.
REQ-022 Out-of-range read (RdAddrX>=DEPTH, RdEnX=1) returns all-zero with RdValidX=1, and sets AddrErr.
REQ-023 AddrErr stays 1 until reset; no other means of clearing it exists.
REQ-024 When DEPTH==2^ADDR, no address is out of range and AddrErr is constant 0.

Reset
REQ-025 RST=1 immediately clears every storage register, RdDataA/B, RdValidA/B and AddrErr to 0, independent of CLK.
REQ-026 While RST=1, writes and reads are ignored.
REQ-027 A write or read in the cycle RST asserts is discarded; storage never holds a partial update.
REQ-028 After deassertion, the first rising edge with valid requests is processed normally.

Structure
REQ-029 Package reg_file_pkg holds the default WIDTH/DEPTH/ADDR constants and the range-check function (addr < DEPTH).
REQ-030 Sub-module reg_file_rd_port (mux, bypass, output register, valid) is instantiated twice, once for port A and once for port B.
REQ-031 Storage is a flop array of DEPTH x WIDTH; no memory macros or latches.

Verification (WIDTH=16, DEPTH=8, ADDR=3 unless stated)
REQ-032 Reset: assert RST mid-run after writes -> all outputs 0 immediately; a post-reset read of addr 3 returns 16'h0000, RdValid=1.
REQ-033 Write/dual-read: write 16'h000E@0, 16'h000D@1, 16'h000B@2, 16'h0007@3 (mask FFFF); read A=0, B=3 together -> next cycle RdDataA=000E, RdDataB=0007, both valid.
REQ-034 Mask: reg5=16'hAAAA; write 16'h5555 with mask 16'h00FF -> read 5 returns 16'hAA55.
REQ-035 Bypass: reg2=16'h1234; same edge write 16'hFFFF mask 16'hF0F0 @2, RdEnA=1 @2 -> RdDataA=16'hF2F4.
REQ-036 Out-of-range (DEPTH=6): write 16'hBEEF@7 -> AddrErr=1, regs 0..5 unchanged; read B@6 -> RdDataB=0, RdValidB=1; AddrErr remains 1 until RST.
REQ-037 Valid gating: RdEnA pulsed one cycle -> RdValidA high exactly one cycle, RdDataA held afterwards.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and the address range check for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_ADDR  = 3;

  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write-first bypass, output register and valid.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned ADDR  = DEF_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [ADDR-1:0]  rd_addr,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic             wr_fire,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_merge,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  logic             rd_ok;
  logic [ADDR-1:0]  rd_idx;
  logic [WIDTH-1:0] rd_next;

  // Out-of-range reads return zero; a same-edge write to the read address wins.
  always_comb begin
    rd_ok   = addr_ok(32'(rd_addr), DEPTH);
    rd_idx  = rd_ok ? rd_addr : '0;
    rd_next = '0;
    if (rd_ok) begin
      if (wr_fire && (wr_addr == rd_addr)) rd_next = wr_merge;
      else                                 rd_next = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Flop-based register file with one masked write port and two registered read ports.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned ADDR  = DEF_ADDR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WrEn,
  input  logic [ADDR-1:0]  WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] WrMask,
  input  logic             RdEnA,
  input  logic [ADDR-1:0]  RdAddrA,
  input  logic             RdEnB,
  input  logic [ADDR-1:0]  RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB,
  output logic             RdValidA,
  output logic             RdValidB,
  output logic             AddrErr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             wr_fire;
  logic [ADDR-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_merge;
  logic             err_set;

  always_comb begin
    wr_ok    = addr_ok(32'(WrAddr), DEPTH);
    wr_fire  = WrEn && wr_ok;
    wr_idx   = wr_ok ? WrAddr : '0;
    wr_merge = (mem[wr_idx] & ~WrMask) | (WrData & WrMask);
    err_set  = (WrEn  && !wr_ok)
            || (RdEnA && !addr_ok(32'(RdAddrA), DEPTH))
            || (RdEnB && !addr_ok(32'(RdAddrB), DEPTH));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_fire) begin
      mem[wr_idx] <= wr_merge;
    end
  end

  // Sticky until reset; cannot fire when every address is implemented.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          AddrErr <= 1'b0;
    else if (err_set) AddrErr <= 1'b1;
  end

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_rd_a (
    .clk      (CLK),
    .rst      (RST),
    .rd_en    (RdEnA),
    .rd_addr  (RdAddrA),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (WrAddr),
    .wr_merge (wr_merge),
    .rd_data  (RdDataA),
    .rd_valid (RdValidA)
  );

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_rd_b (
    .clk      (CLK),
    .rst      (RST),
    .rd_en    (RdEnB),
    .rd_addr  (RdAddrB),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (WrAddr),
    .wr_merge (wr_merge),
    .rd_data  (RdDataB),
    .rd_valid (RdValidB)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Drives a DEPTH=8 and a DEPTH=6 register file with shared stimulus against an array model.
module tb_reg_file_2r1w;

  logic        CLK;
  logic        RST;
  logic        WrEn;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic [15:0] WrMask;
  logic        RdEnA;
  logic [2:0]  RdAddrA;
  logic        RdEnB;
  logic [2:0]  RdAddrB;
  logic [15:0] da8, db8, da6, db6;
  logic        va8, vb8, va6, vb6, err8, err6;

  int checks;
  int failures;

  // Model state: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 instance.
  int unsigned dep [2];
  logic [15:0] m  [2][8];
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic        eva[2];
  logic        evb[2];
  logic        ee [2];

  reg_file_2r1w dut8 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(da8), .RdDataB(db8), .RdValidA(va8), .RdValidB(vb8), .AddrErr(err8)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR(3)) dut6 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(da6), .RdDataB(db6), .RdValidA(va6), .RdValidB(vb6), .AddrErr(err6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m[k][i] = '0;
      ea[k] = '0; eb[k] = '0; eva[k] = 1'b0; evb[k] = 1'b0; ee[k] = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [15:0] wm, input logic rea, input logic [2:0] ra,
                       input logic reb, input logic [2:0] rb);
    WrEn = we; WrAddr = wa; WrData = wd; WrMask = wm;
    RdEnA = rea; RdAddrA = ra; RdEnB = reb; RdAddrB = rb;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " d8 RdDataA"},  32'(da8),  32'(ea[0]));
    check({tag, " d8 RdDataB"},  32'(db8),  32'(eb[0]));
    check({tag, " d8 RdValidA"}, 32'(va8),  32'(eva[0]));
    check({tag, " d8 RdValidB"}, 32'(vb8),  32'(evb[0]));
    check({tag, " d8 AddrErr"},  32'(err8), 32'(ee[0]));
    check({tag, " d6 RdDataA"},  32'(da6),  32'(ea[1]));
    check({tag, " d6 RdDataB"},  32'(db6),  32'(eb[1]));
    check({tag, " d6 RdValidA"}, 32'(va6),  32'(eva[1]));
    check({tag, " d6 RdValidB"}, 32'(vb6),  32'(evb[1]));
    check({tag, " d6 AddrErr"},  32'(err6), 32'(ee[1]));
  endtask

  // Model is write-first: apply the write, then read the updated array.
  task automatic step(input string tag);
    for (int k = 0; k < 2; k++) begin
      if (WrEn) begin
        if (32'(WrAddr) < dep[k]) m[k][WrAddr] = (m[k][WrAddr] & ~WrMask) | (WrData & WrMask);
        else ee[k] = 1'b1;
      end
      eva[k] = RdEnA;
      if (RdEnA) begin
        if (32'(RdAddrA) < dep[k]) ea[k] = m[k][RdAddrA];
        else begin ea[k] = '0; ee[k] = 1'b1; end
      end
      evb[k] = RdEnB;
      if (RdEnB) begin
        if (32'(RdAddrB) < dep[k]) eb[k] = m[k][RdAddrB];
        else begin eb[k] = '0; ee[k] = 1'b1; end
      end
    end
    @(posedge CLK);
    #1;
    compare_all(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    dep[0] = 8;
    dep[1] = 6;
    model_reset();
    RST = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    @(posedge CLK);
    #1;
    compare_all("reset");
    RST = 1'b0;

    drive(1'b1, 3'd0, 16'h000E, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr0");
    drive(1'b1, 3'd1, 16'h000D, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr1");
    drive(1'b1, 3'd2, 16'h000B, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr2");
    drive(1'b1, 3'd3, 16'h0007, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr3");
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd3);        step("dual");
    check("dual A const", 32'(da8), 32'h000E);
    check("dual B const", 32'(db8), 32'h0007);
    check("dual valid const", 32'({va8, vb8}), 32'h3);

    drive(1'b1, 3'd5, 16'hAAAA, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr5");
    drive(1'b1, 3'd5, 16'h5555, 16'h00FF, 1'b0, 3'd0, 1'b0, 3'd0); step("mask5");
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);        step("rd5");
    check("mask const", 32'(da8), 32'hAA55);

    drive(1'b1, 3'd1, 16'hFFFF, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0); step("zero mask");
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd1);        step("rd1");
    check("zero mask const", 32'(db8), 32'h000D);

    drive(1'b1, 3'd2, 16'h1234, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("wr2b");
    drive(1'b1, 3'd2, 16'hFFFF, 16'hF0F0, 1'b1, 3'd2, 1'b0, 3'd0); step("bypass");
    check("bypass const", 32'(da8), 32'hF2F4);

    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd0);        step("pulse");
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd7, 1'b0, 3'd0);        step("idle1");
    check("pulse hold const", 32'({va8, da8}), 32'h0000E);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd2, 1'b0, 3'd0);        step("idle2");

    drive(1'b1, 3'd7, 16'hBEEF, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0); step("oor wr");
    check("oor wr err const", 32'({err6, err8}), 32'h2);
    for (int i = 0; i < 6; i += 2) begin
      drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(i + 1));
      step("scan6");
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd6);        step("oor rd");
    check("oor rd const", 32'({vb6, db6}), 32'h10000);

    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 3'($urandom_range(7)), 16'($urandom),
            ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom),
            1'($urandom), 3'($urandom_range(7)), 1'($urandom), 3'($urandom_range(7)));
      step("rand");
    end

    // Mid-cycle reset with a write pending: outputs clear at once and the write is dropped.
    drive(1'b1, 3'd3, 16'hFFFF, 16'hFFFF, 1'b1, 3'd3, 1'b1, 3'd6);
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    compare_all("async rst");
    @(posedge CLK);
    #1;
    compare_all("rst held");
    RST = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd3);        step("post rst");
    check("post rst const", 32'({va8, da8}), 32'h10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
